// File: rtl/inst_arb_merge_pkg.sv
// rtl/inst_arb_merge_pkg.sv - shared types and constants for the instruction merge arbiter
package inst_arb_pkg;

    localparam int PKT_W     = 18;
    localparam int SRC_W     = 4;
    localparam int CONTENT_W = 14;

    // Content-type field positions inside the 14-bit content word.
    localparam int         CT_FILTER_BIT = 0;      // 0 = ifmap, 1 = filter
    localparam logic [1:0] CT_NEW_IFMAP  = 2'b00;  // content[1:0] marks a new ifmap set

    typedef struct packed {
        logic [CONTENT_W-1:0] content;
        logic [SRC_W-1:0]     pe_node;
    } pkt_t;

    function automatic logic is_new_ifmap(input pkt_t p);
        return p.content[1:0] == CT_NEW_IFMAP;
    endfunction

    function automatic logic is_filter(input pkt_t p);
        return p.content[CT_FILTER_BIT];
    endfunction

endpackage

// File: rtl/inst_arb_merge_if.sv
// rtl/inst_arb_merge_if.sv - handshake bundle between PE FIFOs, merge stage and injection port
//   in_valid/in_data/in_ready : per-source request, packed packets, one-hot accept
//   out_valid/out_data/out_src/out_ready : registered packet toward the network
//   modport master : the merge stage; modport slave : sources plus downstream consumer
interface inst_arb_merge_if
    import inst_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int P_W     = PKT_W,
    parameter int S_W     = SRC_W
);
    logic [NUM_SRC-1:0]     in_valid;
    logic [NUM_SRC*P_W-1:0] in_data;
    logic [NUM_SRC-1:0]     in_ready;
    logic                   out_valid;
    logic [P_W-1:0]         out_data;
    logic [S_W-1:0]         out_src;
    logic                   out_ready;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/inst_arb_merge_rr_pick.sv
// rtl/inst_arb_merge_rr_pick.sv - combinational round-robin priority finder
//   req     : request vector
//   ptr     : index where the search starts (highest priority)
//   gnt_idx : first requesting index at or after ptr, wrapping modulo N
//   gnt_any : at least one request present
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);
    localparam int SW = W + 1;

    logic [SW-1:0] sum;
    logic [W-1:0]  cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so ptr+i never overflows before the explicit
            // wrap; this keeps non-power-of-two N correct.
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[W-1:0];
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end
endmodule

// File: rtl/inst_arb_merge.sv
// rtl/inst_arb_merge.sv - N-to-1 round-robin merge of PE instruction FIFOs into one registered output
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_arb_merge_if.master (sources in, network injection out)
//   tag_err  : sticky PE_node tag mismatch flag, only with INST_ARB_TAG_CHK_EN
module inst_arb_merge
    import inst_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    inst_arb_merge_if.master   bus
`ifdef INST_ARB_TAG_CHK_EN
    ,
    output logic               tag_err
`endif
);
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             gnt_any;
    logic             load_ok;
    logic             xfer;
    pkt_t             win_pkt;

    rr_pick #(.N(NUM_SRC), .W(IDX_W)) u_pick (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Output register is free when empty or being drained this cycle,
    // which allows one packet per cycle under back-to-back accept.
    assign load_ok  = !bus.out_valid || bus.out_ready;
    assign xfer     = gnt_any && load_ok && !rst;
    assign win_pkt  = bus.in_data[int'(gnt_idx)*PKT_W +: PKT_W];
    assign next_ptr = (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= win_pkt;
            bus.out_src   <= SRC_W'(gnt_idx);
            rr_ptr        <= next_ptr;
        end else if (bus.out_ready) begin
            // Drain without refill; out_data keeps its last value.
            bus.out_valid <= 1'b0;
        end
    end

`ifdef INST_ARB_TAG_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (xfer && (win_pkt.pe_node != SRC_W'(gnt_idx))) begin
            tag_err <= 1'b1;
            $error("inst_arb_merge: source %0d supplied PE_node tag %0h", gnt_idx, win_pkt.pe_node);
        end
    end
`endif
endmodule

// File: tb/tb_inst_arb_merge.sv
// tb/tb_inst_arb_merge.sv - directed scoreboard bench for inst_arb_merge
module tb_inst_arb_merge;
    localparam int NS = 4;
    localparam int PW = 18;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [21:0] sb[$];   // {src[3:0], data[17:0]}
    logic [PW-1:0] dsrc[NS];

    always #5 clk = ~clk;

    inst_arb_merge_if #(.NUM_SRC(NS)) bus();

`ifdef INST_ARB_TAG_CHK_EN
    logic tag_err;
    inst_arb_merge #(.NUM_SRC(NS)) dut (.clk(clk), .rst(rst), .bus(bus), .tag_err(tag_err));
`else
    inst_arb_merge #(.NUM_SRC(NS)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always_comb begin
        for (int i = 0; i < NS; i++) bus.in_data[i*PW +: PW] = dsrc[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs are set before the call; samples at negedge, then advances to posedge+1.
    // exp_g: expected grant index (-1 none); exp_ov: expected out_valid (-1 skip).
    task automatic cycle(input int exp_g, input int exp_ov);
        logic [21:0] e;
        logic [NS-1:0] er;
        @(negedge clk);
        er = (exp_g < 0) ? '0 : NS'(1 << exp_g);
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        if (exp_ov >= 0) chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e[17:0]));
                chk("out_src", 32'(bus.out_src), 32'(e[21:18]));
            end
        end
        if (exp_g >= 0) sb.push_back({4'(exp_g), dsrc[exp_g]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NS; i++) dsrc[i] = 18'h3FFF0 | 18'(i);
        @(posedge clk);
        #1;

        // Reset hold with every source requesting.
        for (int k = 0; k < 3; k++) cycle(-1, 0);
        rst = 1'b0;

        // Full contention: strict rotation, no gaps.
        for (int k = 0; k < 8; k++) cycle(k % NS, (k == 0) ? 0 : 1);

        // Backpressure: only source 1 requests first, pointer then sits at 2.
        bus.in_valid = 4'b0010;
        dsrc[1] = 18'h00A51;
        cycle(1, 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle(-1, 1);
            chk("stall_data", 32'(bus.out_data), 32'h00A51);
            chk("stall_src", 32'(bus.out_src), 32'd1);
        end
        bus.out_ready = 1'b1;
        cycle(2, 1);

        // Sparse: move pointer to 2, then sources 1 and 3 alternate via wrap.
        bus.in_valid = 4'b0010;
        cycle(1, 1);
        bus.in_valid = 4'b1010;
        cycle(3, 1);
        cycle(1, 1);
        cycle(3, 1);
        bus.in_valid = 4'b0000;
        cycle(-1, 1);
        cycle(-1, 0);

        // Drain: single packet, out_valid high exactly one cycle.
        dsrc[2] = 18'h12345;
        bus.in_valid = 4'b0100;
        cycle(2, 0);
        bus.in_valid = 4'b0000;
        cycle(-1, 1);
        cycle(-1, 0);
        chk("drain_hold", 32'(bus.out_data), 32'h12345);

`ifdef INST_ARB_TAG_CHK_EN
        rst = 1'b1;
        cycle(-1, -1);
        rst = 1'b0;
        sb.delete();
        chk("tag_err_clear", 32'(tag_err), 32'd0);
        dsrc[1] = {14'h0055, 4'h3};
        bus.in_valid = 4'b0010;
        cycle(1, 0);
        bus.in_valid = 4'b0000;
        chk("tag_err_set", 32'(tag_err), 32'd1);
        cycle(-1, 1);
        cycle(-1, 0);
        chk("tag_err_sticky", 32'(tag_err), 32'd1);
`endif

        // Reset mid-transfer discards the held packet and restarts at source 0.
        bus.in_valid = 4'b0001;
        cycle(0, -1);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        cycle(-1, 1);
        sb.delete();
        cycle(-1, 0);
`ifdef INST_ARB_TAG_CHK_EN
        chk("tag_err_rst", 32'(tag_err), 32'd0);
`endif
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        cycle(0, 0);
        cycle(1, 1);
        bus.in_valid = 4'b0000;
        cycle(-1, 1);
        cycle(-1, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_arb_merge.md
Name: inst_arb_merge

Overview:
- Clocked N-to-1 round-robin merge stage directly downstream of the per-PE instruction FIFOs.
- Each FIFO presents an 18-bit packet {FIFO_content[17:4], PE_node[3:0]}.
- The block picks one ready requester per cycle, registers the winning packet and forwards it to the network injection port over a valid/ready handshake.
- Guarantees starvation-free service and in-order delivery per source.

Parameters:
- NUM_SRC, 4, number of upstream FIFOs (2..16).
- PKT_W, 18, packet width: 14-bit content plus 4-bit PE_node.
- SRC_W, 4, width of the PE_node tag field (bits [3:0]).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_SRC  per-source request; bit i belongs to source i.
- in_data  in  NUM_SRC*PKT_W  packed packets; source i occupies [i*PKT_W +: PKT_W].
- in_ready  out  NUM_SRC  one-hot (or zero) accept strobe to the sources.
- out_valid  out  1  output register holds a packet.
- out_data  out  PKT_W  registered packet, unmodified.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_src  out  SRC_W  index of the source that supplied out_data.
- tag_err  out  1  sticky tag-mismatch flag; present only with INST_ARB_TAG_CHK_EN.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=0, tag_err=0. in_ready is combinational and is 0 while rst=1.
- Load condition: load_ok = !out_valid || out_ready. The output is a single register stage and supports full throughput: one packet per cycle with back-to-back accept.
- Arbitration (combinational):
  - Scan the in_valid bits starting at rr_ptr and wrapping modulo NUM_SRC.
  - The first asserted bit wins, giving grant index g.
  - in_ready[g]=load_ok. All other in_ready bits are 0.
  - If no in_valid bit is set, in_ready=0.
- Transfer: occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g]; out_src <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_SRC. Handle wrap explicitly when NUM_SRC is not a power of 2.
- Drain without refill: if out_valid && out_ready and no transfer occurs, out_valid <= 0. out_data holds its last value.
- Stall: if out_valid && !out_ready, out_data and out_src hold stable and in_ready=0.
- rr_ptr advances only on a transfer. It never moves during a stall or an idle cycle.
- Latency: 1 cycle from the accept edge to out_valid visible.
- Fairness: each continuously requesting source is served at least once every NUM_SRC transfers.
- Sources may drop in_valid without a transfer. The arbiter re-evaluates every cycle, so there is no grant lock.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- The packet is not modified. PE_node is taken from the packet as supplied.
- Reset mid-transfer: an in-flight out_valid packet is discarded. Sources see in_ready=0 during reset, so no packet is consumed.

Optional Feature:
- Macro: INST_ARB_TAG_CHK_EN.
- Defined:
  - On every transfer, compare in_data[g][3:0] with g.
  - On mismatch, set tag_err <= 1 (sticky until rst). The packet is still forwarded unchanged.
  - Also fire a simulation $error naming g and the tag.
- Undefined: the tag_err port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package inst_arb_pkg holds:
  - localparams PKT_W=18, SRC_W=4, CONTENT_W=14.
  - typedef pkt_t as a packed struct {content[13:0], pe_node[3:0]}.
  - Content-type field positions: content bit 0 is ifmap(0)/filter(1); content bits [1:0]==2'b00 marks a new ifmap set.
- One sub-module, rr_pick: parameterised round-robin priority finder with inputs req and ptr and outputs gnt_idx and gnt_any. It is purely combinational and is reused by later network arbiters.

Test Plan:
- Reset: hold rst 3 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout; first grant after release goes to source 0.
- Full contention: NUM_SRC=4, all valid, out_ready=1, each source i sends 0x3_FFF0|i -> out_src sequence 0,1,2,3,0,1,..., one packet per cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles with out_data=0x00A51 -> out_data and out_src stable, in_ready=0, rr_ptr unchanged; after release the next grant resumes at the saved pointer.
- Sparse requests: only sources 1 and 3 valid, rr_ptr=2 -> grant 3 then 1, pointer wraps to 0 then 2.
- Drain: a single packet 0x12345 from source 2, then idle -> out_valid is high exactly 1 cycle with out_ready=1, then drops to 0.
- Tag check (macro on): source 1 sends a packet with tag 4'h3 -> packet forwarded, tag_err=1 on the next cycle and it stays set until rst.
